// File: rtl/axis_unpack_lanes_pkg.sv
// rtl/axis_unpack_lanes_pkg.sv - shared widths, lane record layout helpers and lowest-set-bit encoder
package axis_unpack_lanes_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    function automatic int keep_width(input int data_width);
        return (data_width + 7) / 8;
    endfunction

    function automatic int rec_width(input int data_width, input int enable_keep);
        return data_width + 1 + ((enable_keep != 0) ? keep_width(data_width) : 0);
    endfunction

    function automatic int idx_width(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Lane 0 sits in the MSBs of the packed word.
    function automatic int rec_lsb(input int lane, input int lanes, input int rec_w);
        return (lanes - 1 - lane) * rec_w;
    endfunction

    function automatic int last_offset(input int data_width, input int enable_keep);
        return (enable_keep != 0) ? keep_width(data_width) : 0;
    endfunction

    function automatic int data_offset(input int data_width, input int enable_keep);
        return last_offset(data_width, enable_keep) + 1;
    endfunction

    function automatic logic [5:0] lowest_set(input logic [63:0] mask);
        logic [5:0] idx;
        idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (mask[i]) idx = 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/axis_unpack_lanes_skid_reg.sv
// rtl/axis_unpack_lanes_skid_reg.sv - two-entry stream register slice with registered in_tready
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready
);
    logic [WIDTH-1:0] mem_q [2];
    logic             rd_q;
    logic             wr_q;
    logic [1:0]       count_q;
    logic             in_fire;
    logic             out_fire;

    assign in_tready  = (count_q != 2'd2);
    assign out_tvalid = (count_q != 2'd0);
    assign out_tdata  = out_tvalid ? mem_q[rd_q] : '0;
    assign in_fire    = in_tvalid && in_tready;
    assign out_fire   = out_tvalid && out_tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (in_fire) begin
                mem_q[wr_q] <= in_tdata;
                wr_q        <= ~wr_q;
            end
            if (out_fire) rd_q <= ~rd_q;
            count_q <= count_q + {1'b0, in_fire} - {1'b0, out_fire};
        end
    end

endmodule

// File: rtl/axis_unpack_lanes.sv
// rtl/axis_unpack_lanes.sv - serialises packed lane records onto a narrow stream; AXIS_UNPACK_LANES_OUT_REG_EN adds an output skid slice
module axis_unpack_lanes
    import axis_unpack_lanes_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 4,
    parameter int ENABLE_KEEP = 0,
    parameter int DEST_WIDTH  = 16,
    localparam int KEEP_WIDTH = keep_width(DATA_WIDTH),
    localparam int REC_W      = rec_width(DATA_WIDTH, ENABLE_KEEP),
    localparam int IDX_W      = idx_width(LANES)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [LANES*REC_W-1:0] left_TDATA,
    input  logic [LANES-1:0]       left_TLANES,
    input  logic [DEST_WIDTH-1:0]  left_TDEST,
    input  logic                   left_TVALID,
    output logic                   left_TREADY,
    output logic [DATA_WIDTH-1:0]  right_TDATA,
    output logic                   right_TLAST,
    output logic [KEEP_WIDTH-1:0]  right_TKEEP,
    output logic [DEST_WIDTH-1:0]  right_TDEST,
    output logic [IDX_W-1:0]       right_TID,
    output logic                   right_TVALID,
    input  logic                   right_TREADY
);
    localparam int LAST_OFF = last_offset(DATA_WIDTH, ENABLE_KEEP);
    localparam int DATA_OFF = data_offset(DATA_WIDTH, ENABLE_KEEP);

    state_t                 state_q, state_n;
    logic [LANES*REC_W-1:0] word_q, word_n;
    logic [DEST_WIDTH-1:0]  dest_q, dest_n;
    logic [LANES-1:0]       pend_q, pend_n;
    logic [LANES-1:0]       cur_onehot;
    logic [5:0]             cur_lane;
    logic [REC_W-1:0]       cur_rec;
    logic                   rdy_q;
    logic                   busy;
    logic                   last_lane;
    logic                   core_ready;
    logic                   core_fire;
    logic                   left_fire;
    logic [DATA_WIDTH-1:0]  core_data;
    logic                   core_last;
    logic [KEEP_WIDTH-1:0]  core_keep;
    logic [DEST_WIDTH-1:0]  core_dest;
    logic [IDX_W-1:0]       core_id;

    assign busy       = (state_q == ST_EMIT);
    assign cur_lane   = lowest_set(64'(pend_q));
    assign cur_onehot = LANES'(1) << cur_lane;
    assign last_lane  = ((pend_q & ~cur_onehot) == '0);
    assign core_fire  = busy && core_ready;
    // rdy_q keeps left_TREADY low throughout reset and releases it one edge later.
    assign left_TREADY = rdy_q && (!busy || (core_fire && last_lane));
    assign left_fire   = left_TVALID && left_TREADY;

    always_comb begin
        cur_rec = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cur_lane == 6'(i)) cur_rec = word_q[rec_lsb(i, LANES, REC_W) +: REC_W];
        end
    end

    always_comb begin
        word_n = word_q;
        dest_n = dest_q;
        pend_n = pend_q;
        if (left_fire) begin
            word_n = left_TDATA;
            dest_n = left_TDEST;
            pend_n = left_TLANES;
        end else if (core_fire) begin
            pend_n = pend_q & ~cur_onehot;
        end
        state_n = (pend_n != '0) ? ST_EMIT : ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            dest_q  <= '0;
            pend_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            word_q  <= word_n;
            dest_q  <= dest_n;
            pend_q  <= pend_n;
            rdy_q   <= 1'b1;
        end
    end

    // Payload is forced to zero whenever no beat is offered.
    assign core_data = busy ? cur_rec[DATA_OFF +: DATA_WIDTH] : '0;
    assign core_last = busy && cur_rec[LAST_OFF];
    assign core_dest = busy ? dest_q : '0;
    assign core_id   = busy ? cur_lane[IDX_W-1:0] : '0;

    generate
        if (ENABLE_KEEP != 0) begin : g_keep
            assign core_keep = busy ? cur_rec[0 +: KEEP_WIDTH] : '0;
        end else begin : g_no_keep
            assign core_keep = {KEEP_WIDTH{busy}};
        end
    endgenerate

`ifdef AXIS_UNPACK_LANES_OUT_REG_EN
    localparam int PAY_W = DATA_WIDTH + 1 + KEEP_WIDTH + DEST_WIDTH + IDX_W;

    logic [PAY_W-1:0] slice_out;

    axis_skid_reg #(.WIDTH(PAY_W)) u_out_slice (
        .clk        (clk),
        .resetn     (resetn),
        .in_tdata   ({core_data, core_last, core_keep, core_dest, core_id}),
        .in_tvalid  (busy),
        .in_tready  (core_ready),
        .out_tdata  (slice_out),
        .out_tvalid (right_TVALID),
        .out_tready (right_TREADY)
    );

    assign {right_TDATA, right_TLAST, right_TKEEP, right_TDEST, right_TID} = slice_out;
`else
    assign core_ready   = right_TREADY;
    assign right_TVALID = busy;
    assign right_TDATA  = core_data;
    assign right_TLAST  = core_last;
    assign right_TKEEP  = core_keep;
    assign right_TDEST  = core_dest;
    assign right_TID    = core_id;
`endif

endmodule

// File: doc/axis_unpack_lanes.md
# axis_unpack_lanes

Sequential successor to the combinational side-channel splitter. It accepts one wide AXI-Stream word carrying LANES packed lane records, each record holding data plus embedded TLAST and optional TKEEP, and serialises the records onto a narrow AXI-Stream output at one beat per cycle. Empty lanes are skipped. The lane index is emitted on TID. It sits between wide HLS kernels and narrow network-facing streams in the middleware.

## Interface
- DATA_WIDTH, 32: data bits per lane record and on right_TDATA.
- LANES, 4: lane records per input word; legal range 1..64.
- ENABLE_KEEP, 0: nonzero means each record carries KEEP_WIDTH=(DATA_WIDTH+7)/8 keep bits and right_TKEEP is driven from them; 0 means right_TKEEP is all ones.
- DEST_WIDTH, 16: width of left_TDEST and right_TDEST; minimum 1.
- clk  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous assert, active-low reset.
- left_TDATA  in  LANES*REC_W  packed records. REC_W=DATA_WIDTH+1+ENABLE_KEEP*KEEP_WIDTH. Lane 0 occupies the MSBs. Each record is {data, last, keep}, MSB first.
- left_TLANES  in  LANES  lane-valid mask; bit i set means lane i holds a beat.
- left_TDEST  in  DEST_WIDTH  applied to every beat produced from the word.
- left_TVALID  in  1;  left_TREADY  out  1.
- right_TDATA  out  DATA_WIDTH;  right_TLAST  out  1;  right_TKEEP  out  KEEP_WIDTH.
- right_TDEST  out  DEST_WIDTH;  right_TID  out  IDX_W  source lane index, IDX_W=max(1,clog2(LANES)).
- right_TVALID  out  1;  right_TREADY  in  1.

## Operation
- The holding register stores the record word, the DEST value and the pending mask. busy = (pending mask != 0).
- Two states:
  - IDLE: pending mask is zero.
  - EMIT: pending mask is nonzero.
- left_TREADY = !busy OR (right beat accepted this cycle AND it is the last pending lane).
- On a left handshake, load the word, DEST and mask.
- A word whose mask is zero is accepted and discarded; the state stays IDLE.
- Current lane = lowest set bit of the pending mask, found with a fixed priority encoder.
- Outputs present that lane's record, DEST and index.
- On a right handshake, clear the current lane's bit.
- Embedded last is forwarded verbatim. The block neither generates nor checks packet boundaries.
- Simultaneous final-beat accept and new left handshake: the new word loads in the same cycle, with no bubble.
- Held outputs are stable while right_TVALID=1 and right_TREADY=0, per AXI-Stream.
- Reset mid-word: the pending mask clears and the remaining lanes are lost; no partial word survives reset.

## Timing
- Reset values:
  - right_TVALID=0.
  - left_TREADY=0 while resetn=0, and 1 on the first cycle after release.
  - right_TDATA, TLAST, TKEEP, TDEST and TID all read 0.
- Latency from left handshake in cycle N to first right_TVALID is cycle N+1.
- Sustained throughput is one output beat per cycle when right_TREADY is held high.
- A word with k set lanes occupies exactly k output cycles.
- The combinational path right_TREADY -> left_TREADY is permitted in the base configuration.

## Configuration
- AXIS_UNPACK_LANES_OUT_REG_EN:
  - Defined: an output register slice (skid buffer) is inserted after the lane mux.
    - The first beat appears at N+2.
    - Full throughput is kept.
    - There is no combinational path from right_TREADY to left_TREADY.
    - The slice resets to empty.
  - Undefined: outputs are driven directly from the holding register and mux, with latency N+1.

## Structure
- Package axis_unpack_lanes_pkg holds:
  - the KEEP_WIDTH, REC_W and IDX_W functions;
  - the lane record field offset functions;
  - a lowest-set-bit priority encoder function.
- Sub-module axis_skid_reg: a generic two-entry register slice parameterised by payload width. It is instantiated only under the macro.

## Test plan
- LANES=4, DATA_WIDTH=8; word with lanes {AA,BB,CC,DD}, mask 1111, right_TREADY=1.
  - Expect beats AA,BB,CC,DD in 4 consecutive cycles, TID 0..3.
- Same word with mask 1010.
  - Expect exactly 2 beats, BB (TID=1) then DD (TID=3), and left_TREADY returning high the cycle DD is accepted.
- Zero mask word followed by a mask-0001 word.
  - The first word is dropped with no output.
  - The second produces a single beat one cycle after its acceptance.
- Two back-to-back full words with right_TREADY=1.
  - Expect 8 beats with no idle cycle, and DEST switching exactly at beat 5.
- right_TREADY toggled pseudo-randomly at 50% over 100 words with random masks.
  - Expect the output sequence to match the reference model and data to stay stable during stalls.
- resetn pulsed low after 2 of 4 beats.
  - Expect right_TVALID=0 immediately and no remaining lanes emitted after release.
  - Repeat with AXIS_UNPACK_LANES_OUT_REG_EN defined, expecting first-beat latency N+2.
